// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes and the serial add/sub sequencer states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from per-bit full adders.
module add_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // One full adder per bit; carry ripples from bit 0 upwards.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit: ripples CHUNK bits per cycle, then presents
// the result and ALU flags behind a valid/ready handshake.
module serial_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Reject illegal parameter combinations at elaboration.
    if (WIDTH < 2 || CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic             a_msb, b_msb;

    logic             accept_c, last_c;
    logic [WIDTH-1:0] b_eff_c;
    logic             cin0_c;
    logic [CHUNK-1:0] ch_sum_c;
    logic             ch_cout_c;
    logic [WIDTH-1:0] res_c;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign accept_c  = in_valid && in_ready;
    assign last_c    = (k_q == KW'(NCHUNK - 1));

    // Operand conditioning: subtract is a + ~b + 1, with-carry modes use c_in.
    always_comb begin
        b_eff_c = b;
        cin0_c  = 1'b0;
        case (op_t'(op))
            OP_ADD: begin b_eff_c = b;  cin0_c = 1'b0; end
            OP_ADC: begin b_eff_c = b;  cin0_c = c_in; end
            OP_SUB: begin b_eff_c = ~b; cin0_c = 1'b1; end
            OP_SBB: begin b_eff_c = ~b; cin0_c = c_in; end
            default: ;
        endcase
    end

    // Single shared chunk adder, fed from the low end of the operand shifters.
    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (carry_q),
        .sum  (ch_sum_c),
        .cout (ch_cout_c)
    );

    // New chunk enters the accumulator at the top; after NCHUNK shifts it is aligned.
    assign res_c = WIDTH'({ch_sum_c, acc} >> CHUNK);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c)  state_d = S_RUN;
            S_RUN:   if (last_c)    state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath: latch operands on accept, ripple one chunk per RUN cycle, register flags at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (accept_c) begin
            a_sh    <= a;
            b_sh    <= b_eff_c;
            acc     <= '0;
            carry_q <= cin0_c;
            k_q     <= '0;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b_eff_c[WIDTH-1];
        end else if (state_q == S_RUN) begin
            a_sh    <= a_sh >> CHUNK;
            b_sh    <= b_sh >> CHUNK;
            acc     <= res_c;
            carry_q <= ch_cout_c;
            k_q     <= k_q + KW'(1);
            if (last_c) begin
                sum      <= res_c;
                carry    <= ch_cout_c;
                overflow <= (a_msb == b_msb) && (res_c[WIDTH-1] != a_msb);
                zero     <= (res_c == '0);
                negative <= res_c[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at 16/4 and 32/8 against an arithmetic model.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv16, ir16, ci16, ov16, or16, cy16, of16, z16, n16, busy16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, sum16;
    logic        iv32, ir32, ci32, ov32, or32, cy32, of32, z32, n32, busy32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, sum32;

    int n_assert = 0;
    int n_fail   = 0;

    serial_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op(op16),
        .a(a16), .b(b16), .c_in(ci16), .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .carry(cy16), .overflow(of16), .zero(z16),
        .negative(n16), .busy(busy16)
    );

    serial_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op32),
        .a(a32), .b(b32), .c_in(ci32), .out_valid(ov32), .out_ready(or32),
        .sum(sum32), .carry(cy32), .overflow(of32), .zero(z32),
        .negative(n32), .busy(busy32)
    );

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    // Bundle layout: {negative, zero, overflow, carry, sum[31:0]}
    function automatic logic [35:0] outs(input int w);
        if (w == 16) return {n16, z16, of16, cy16, 16'h0, sum16};
        return {n32, z32, of32, cy32, sum32};
    endfunction

    function automatic logic ov_of(input int w);
        return (w == 16) ? ov16 : ov32;
    endfunction

    function automatic logic ir_of(input int w);
        return (w == 16) ? ir16 : ir32;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 16) ? busy16 : busy32;
    endfunction

    task automatic drive(input int w, input logic v, input logic [1:0] o,
                         input logic [31:0] xa, input logic [31:0] xb, input logic c);
        if (w == 16) begin
            iv16 = v; op16 = o; a16 = xa[15:0]; b16 = xb[15:0]; ci16 = c;
        end else begin
            iv32 = v; op32 = o; a32 = xa; b32 = xb; ci32 = c;
        end
    endtask

    task automatic set_ordy(input int w, input logic r);
        if (w == 16) or16 = r;
        else         or32 = r;
    endtask

    // Reference: whole-word integer arithmetic, overflow from the signed range.
    function automatic logic [35:0] model(input int w, input logic [1:0] o,
                                          input logic [31:0] xa, input logic [31:0] xb,
                                          input logic c);
        longint mask, ua, ub, c0, tot, s, sa, sb, r, half;
        logic cy, ovf, z, n;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(xa) & mask;
        ub   = ((o == 2'b10 || o == 2'b11) ? ~longint'(xb) : longint'(xb)) & mask;
        c0   = (o == 2'b00) ? 0 : (o == 2'b10) ? 1 : longint'(c);
        tot  = ua + ub + c0;
        s    = tot & mask;
        cy   = ((tot >> w) & 1) != 0;
        sa   = (ua >= half) ? ua - (half * 2) : ua;
        sb   = (ub >= half) ? ub - (half * 2) : ub;
        r    = sa + sb + c0;
        ovf  = (r > half - 1) || (r < -half);
        z    = (s == 0);
        n    = ((s >> (w - 1)) & 1) != 0;
        return {n, z, ovf, cy, 32'(s)};
    endfunction

    // Issue one op, check latency, result, optional backpressure hold, and release.
    task automatic do_op(input int w, input logic [1:0] o, input logic [31:0] xa,
                         input logic [31:0] xb, input logic c, input int hold,
                         input string tag, output logic [35:0] got);
        logic [35:0] exp;
        int lat;
        exp = model(w, o, xa, xb, c);
        @(negedge clk);
        drive(w, 1'b1, o, xa, xb, c);
        check({tag, " in_ready"}, 64'(ir_of(w)), 64'd1);
        @(negedge clk);
        // Inputs after the handshake must be ignored.
        drive(w, 1'b0, 2'($urandom), $urandom, $urandom, 1'($urandom));
        if (hold == 0) set_ordy(w, 1'b1);
        check({tag, " busy"}, 64'(busy_of(w)), 64'd1);
        lat = 0;
        while (!ov_of(w) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        // out_valid appears on the NCHUNK-th edge after the handshake edge (cycle t+NCHUNK+1).
        check({tag, " latency"}, 64'(lat), 64'd4);
        got = outs(w);
        check({tag, " result"}, 64'(got), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            drive(w, 1'b1, 2'($urandom), $urandom, $urandom, 1'($urandom));
            @(negedge clk);
            check({tag, " hold result"}, 64'(outs(w)), 64'(exp));
            check({tag, " hold valid"}, 64'(ov_of(w)), 64'd1);
            check({tag, " hold in_ready"}, 64'(ir_of(w)), 64'd0);
        end
        drive(w, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        set_ordy(w, 1'b1);
        @(negedge clk);
        check({tag, " released valid"}, 64'(ov_of(w)), 64'd0);
        check({tag, " released in_ready"}, 64'(ir_of(w)), 64'd1);
        set_ordy(w, 1'b0);
    endtask

    initial begin
        logic [35:0] got;
        int w;
        rst = 1'b1;
        drive(16, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        drive(32, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        or16 = 1'b0;
        or32 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outs16", 64'(outs(16)), 64'd0);
        check("reset outs32", 64'(outs(32)), 64'd0);
        check("reset valid16", 64'(ov16), 64'd0);
        check("reset busy16", 64'(busy16), 64'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready16", 64'(ir16), 64'd1);
        check("post-reset in_ready32", 64'(ir32), 64'd1);

        // Directed test-plan scenarios at 16/4.
        do_op(16, 2'b00, 32'h7FFF, 32'h0001, 1'b0, 0, "add16", got);
        check("add16 const", 64'(got), 64'({1'b1, 1'b0, 1'b1, 1'b0, 32'h8000}));
        do_op(16, 2'b10, 32'h0005, 32'h0005, 1'b0, 0, "sub16", got);
        check("sub16 const", 64'(got), 64'({1'b0, 1'b1, 1'b0, 1'b1, 32'h0}));
        do_op(16, 2'b01, 32'hFFFF, 32'h0000, 1'b1, 0, "adc16", got);
        check("adc16 const", 64'(got), 64'({1'b0, 1'b1, 1'b0, 1'b1, 32'h0}));
        do_op(16, 2'b11, 32'h0000, 32'h0001, 1'b1, 0, "sbb16", got);
        check("sbb16 const", 64'(got), 64'({1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF}));

        // Backpressure for 3 cycles, then an immediate follow-on op.
        do_op(16, 2'b00, 32'h1357, 32'h2468, 1'b0, 3, "bp16", got);
        do_op(16, 2'b10, 32'h1000, 32'h0001, 1'b0, 0, "after_bp16", got);

        // Reset after two chunks of a RUN.
        @(negedge clk);
        drive(16, 1'b1, 2'b00, 32'hABCD, 32'h4321, 1'b0);
        @(negedge clk);
        drive(16, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun rst valid", 64'(ov16), 64'd0);
        check("midrun rst busy", 64'(busy16), 64'd0);
        check("midrun rst outs", 64'(outs(16)), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrun rst in_ready", 64'(ir16), 64'd1);
        do_op(16, 2'b00, 32'h1234, 32'h1111, 1'b0, 0, "fresh16", got);
        check("fresh16 const", 64'(got), 64'({1'b0, 1'b0, 1'b0, 1'b0, 32'h2345}));

        // Same scenarios at 32/8.
        do_op(32, 2'b00, 32'h7FFF_FFFF, 32'h1, 1'b0, 0, "add32", got);
        check("add32 const", 64'(got), 64'({1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000}));
        do_op(32, 2'b10, 32'h5, 32'h5, 1'b0, 0, "sub32", got);
        check("sub32 const", 64'(got), 64'({1'b0, 1'b1, 1'b0, 1'b1, 32'h0}));
        do_op(32, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, "adc32", got);
        check("adc32 const", 64'(got), 64'({1'b0, 1'b1, 1'b0, 1'b1, 32'h0}));
        do_op(32, 2'b11, 32'h0, 32'h1, 1'b1, 0, "sbb32", got);
        check("sbb32 const", 64'(got), 64'({1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF}));

        // Randomized ops on both widths.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            w  = (i % 2 == 1) ? 32 : 16;
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            do_op(w, 2'($urandom_range(0, 3)), ra, rb, 1'($urandom),
                  int'($urandom_range(0, 2)), "rand", got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Multi-cycle, parametrised add/subtract unit for the CPU datapath. It generalises the 16-bit ripple adder in three ways: width is configurable, carry ripples through CHUNK bits per cycle to keep the critical path short, and it adds subtract/with-carry modes and ALU status flags. Operand transfer uses valid/ready handshakes, so the ALU sequencer can stall on it.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be ≥ 2.
- CHUNK, 4, bits added per cycle; WIDTH % CHUNK == 0 is required, otherwise elaboration fails.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  operation: 00 ADD, 01 ADC, 10 SUB, 11 SBB.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry input, used by ADC/SBB only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result.
- carry  out  1  carry out of MSB. For SUB/SBB, 1 means no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.
- negative  out  1  sum[WIDTH-1].
- busy  out  1  state != IDLE.

## Operation
- NCHUNK = WIDTH/CHUNK.
- Effective operand b_eff: b for ADD/ADC, ~b for SUB/SBB.
- Initial carry: ADD 0, SUB 1, ADC/SBB c_in.
- Acceptance (in_valid && in_ready, IDLE):
  - Latches a, b_eff, and initial carry.
  - Clears the chunk index k to 0.
  - Moves to RUN.
  - Input changes after acceptance are ignored.
- RUN, one chunk per cycle:
  - sum[k*CHUNK +: CHUNK] = a_chunk + b_eff_chunk + carry_reg.
  - carry_reg ← chunk carry-out.
  - k increments.
  - After chunk NCHUNK-1: compute flags and go to DONE.
- Flags, registered on entry to DONE:
  - carry = final carry_reg.
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - zero = (sum == 0).
  - negative = sum[MSB].
- DONE:
  - out_valid = 1; sum and flags held stable.
  - On out_valid && out_ready, go to IDLE.
  - in_ready stays 0 until IDLE is reached.
- State transitions:
  - IDLE → RUN on accept.
  - RUN → RUN while k < NCHUNK-1.
  - RUN → DONE at k == NCHUNK-1.
  - DONE → IDLE on out_ready.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Reset (asynchronous, any state, including mid-RUN):
  - State → IDLE.
  - out_valid, busy, sum, carry, overflow, zero, negative → 0.
  - k, carry_reg → 0.
  - in_ready → 1 once rst deasserts.
  - Any partial result is discarded and is never presented.

## Timing
- Handshake edge at cycle t: RUN occupies cycles t+1 … t+NCHUNK, and out_valid is high from cycle t+NCHUNK+1.
- Default parameters give out_valid 5 cycles after acceptance.
- Minimum issue interval is NCHUNK+2 cycles (RUN, DONE, IDLE).
- If out_ready is already high when out_valid rises, the result is consumed in that cycle.
- in_ready is combinational from state; there is no combinational path from in_valid to in_ready.
- out_valid does not depend combinationally on out_ready.
- While out_valid && !out_ready, all outputs hold for any number of cycles.
- Critical path: one CHUNK-bit ripple plus carry register.

## Structure
- Shared package alu_pkg:
  - op_t enum (OP_ADD, OP_ADC, OP_SUB, OP_SBB).
  - State enum (S_IDLE, S_RUN, S_DONE).
- Sub-module add_chunk, combinational:
  - Ports: CHUNK-bit a, b, cin → sum, cout.
  - Built from per-bit full adders: sum = a^b^cin, cout = (a&b) | ((a^b)&cin).
  - Instantiated once and reused every cycle.
- Top level holds the FSM, operand/result shift or index registers, and flag logic.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- ADD 0x7FFF + 0x0001 → sum 0x8000, overflow=1, carry=0, negative=1, zero=0; out_valid exactly 5 cycles after accept.
- SUB 0x0005 − 0x0005 → sum 0x0000, zero=1, carry=1, overflow=0.
- ADC 0xFFFF + 0x0000 with c_in=1 → sum 0x0000, carry=1, zero=1.
- SBB 0x0000 − 0x0001 with c_in=1 → sum 0xFFFF, carry=0, negative=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, with in_valid=1 and changing a/b:
  - Outputs are unchanged; in_ready=0; no new op is accepted.
  - On release, the next op is accepted in the following IDLE cycle.
- Reset mid-RUN after 2 chunks: out_valid and all flags are 0 immediately, and in_ready=1 after deassert. A fresh ADD 0x1234 + 0x1111 → 0x2345 with no stale data.
- Rerun the first four scenarios with WIDTH=32, CHUNK=8: out_valid after 5 cycles, with results sign/zero-extended equivalently.
